// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one registered-address sprite ROM between the P1 and P2 renderers.
// Supports locked bursts with a forced hand-off, and routes read data back to the requester with a valid pulse.
module sprite_rom_arbiter #(
    parameter int ROW_W     = 10,
    parameter int COL_W     = 10,
    parameter int COLOR_W   = 12,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1_req,
    input  logic               p1_lock,
    input  logic [ROW_W-1:0]   p1_row,
    input  logic [COL_W-1:0]   p1_col,
    output logic               p1_gnt,
    output logic               p1_valid,
    output logic [COLOR_W-1:0] p1_data,
    input  logic               p2_req,
    input  logic               p2_lock,
    input  logic [ROW_W-1:0]   p2_row,
    input  logic [COL_W-1:0]   p2_col,
    output logic               p2_gnt,
    output logic               p2_valid,
    output logic [COLOR_W-1:0] p2_data,
    output logic [ROW_W-1:0]   rom_row,
    output logic [COL_W-1:0]   rom_col,
    input  logic [COLOR_W-1:0] rom_data
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;

    // id: 0 = P1, 1 = P2
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    state_t           state, state_nxt;
    logic             rr_p2, rr_p2_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
    tag_t             stage0, stage1;
    logic             acc1, acc2, acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= MAX_CNT) ? MAX_CNT : v + 1'b1;
    endfunction

    // A burst owner keeps the ROM unless its budget is spent and the other side is waiting.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        p1_gnt = 1'b0;
        p2_gnt = 1'b0;
        if (!reset) begin
            case (state)
                OWN1: begin
                    if (p1_req && (burst_cnt < MAX_CNT || !p2_req)) p1_gnt = 1'b1;
                    else                                            p2_gnt = p2_req;
                end
                OWN2: begin
                    if (p2_req && (burst_cnt < MAX_CNT || !p1_req)) p2_gnt = 1'b1;
                    else                                            p1_gnt = p1_req;
                end
                default: begin
                    if (p1_req && (!p2_req || !rr_p2)) p1_gnt = 1'b1;
                    else                               p2_gnt = p2_req;
                end
            endcase
        end
    end

    assign acc1 = p1_req & p1_gnt;
    assign acc2 = p2_req & p2_gnt;
    assign acc  = acc1 | acc2;

    always_comb begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
        rr_p2_nxt     = rr_p2;
        if (acc1) begin
            rr_p2_nxt = 1'b1;
            if (p1_lock) begin
                state_nxt     = OWN1;
                burst_cnt_nxt = (state == OWN1) ? sat_inc(burst_cnt) : CNT_W'(1);
            end
        end else if (acc2) begin
            rr_p2_nxt = 1'b0;
            if (p2_lock) begin
                state_nxt     = OWN2;
                burst_cnt_nxt = (state == OWN2) ? sat_inc(burst_cnt) : CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_p2     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_p2     <= rr_p2_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Address register, then two tag stages covering the ROM's internal address register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_row <= '0;
            rom_col <= '0;
            stage0  <= '0;
            stage1  <= '0;
        end else begin
            if (acc) begin
                rom_row <= acc1 ? p1_row : p2_row;
                rom_col <= acc1 ? p1_col : p2_col;
            end
            stage0 <= '{valid: acc, id: acc2};
            stage1 <= stage0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            p1_data  <= '0;
            p2_data  <= '0;
        end else begin
            p1_valid <= stage1.valid && !stage1.id;
            p2_valid <= stage1.valid &&  stage1.id;
            if (stage1.valid && !stage1.id) p1_data <= rom_data;
            if (stage1.valid &&  stage1.id) p2_data <= rom_data;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: reset, alternation, burst hand-off, saturation, reset mid-flight, withdrawn request.
// A registered-address ROM model supplies data as a fixed function of row/col.
module tb_sprite_rom_arbiter;

    localparam int ROW_W = 10, COL_W = 10, COLOR_W = 12, MAX_BURST = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               p1_req = 1'b0, p1_lock = 1'b0, p2_req = 1'b0, p2_lock = 1'b0;
    logic [ROW_W-1:0]   p1_row = '0, p2_row = '0;
    logic [COL_W-1:0]   p1_col = '0, p2_col = '0;
    logic               p1_gnt, p2_gnt, p1_valid, p2_valid;
    logic [COLOR_W-1:0] p1_data, p2_data, rom_data;
    logic [ROW_W-1:0]   rom_row;
    logic [COL_W-1:0]   rom_col;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(
        .ROW_W(ROW_W), .COL_W(COL_W), .COLOR_W(COLOR_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_row(p1_row), .p1_col(p1_col),
        .p1_gnt(p1_gnt), .p1_valid(p1_valid), .p1_data(p1_data),
        .p2_req(p2_req), .p2_lock(p2_lock), .p2_row(p2_row), .p2_col(p2_col),
        .p2_gnt(p2_gnt), .p2_valid(p2_valid), .p2_data(p2_data),
        .rom_row(rom_row), .rom_col(rom_col), .rom_data(rom_data)
    );

    function automatic logic [COLOR_W-1:0] rom_f(input int r, input int c);
        return COLOR_W'(r * 37 + c * 11 + 5);
    endfunction

    always @(posedge clk) rom_data <= rom_f(int'(rom_row), int'(rom_col));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p1_req = 1'b0; p1_lock = 1'b0; p2_req = 1'b0; p2_lock = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset: grants forced low even with requests present, outputs cleared.
        reset = 1'b1; p1_req = 1'b1; p2_req = 1'b1;
        #1;
        check("rst_gnt1", p1_gnt, 0);
        check("rst_gnt2", p2_gnt, 0);
        tick(); tick();
        idle_inputs();
        reset = 1'b0;
        #1;
        check("rst_p1_valid", p1_valid, 0);
        check("rst_p2_valid", p2_valid, 0);
        check("rst_p1_data", p1_data, 0);
        check("rst_rom_row", rom_row, 0);
        check("rst_rom_col", rom_col, 0);

        // Single P1 read of (3,5).
        p1_req = 1'b1; p1_row = 3; p1_col = 5;
        #1;
        check("t1_gnt1_c0", p1_gnt, 1);
        check("t1_gnt2_c0", p2_gnt, 0);
        tick();
        p1_req = 1'b0;
        #1;
        check("t1_rom_row", rom_row, 3);
        check("t1_rom_col", rom_col, 5);
        check("t1_valid_c1", p1_valid, 0);
        tick();
        check("t1_valid_c2", p1_valid, 0);
        tick();
        check("t1_valid_c3", p1_valid, 1);
        check("t1_data_c3", p1_data, rom_f(3, 5));
        check("t1_p2valid_c3", p2_valid, 0);
        tick();
        check("t1_valid_c4", p1_valid, 0);
        check("t1_hold_c4", p1_data, rom_f(3, 5));

        // Both request, no lock: strict alternation starting with P1.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                p1_req = 1'b1; p1_row = ROW_W'(10 + i); p1_col = COL_W'(i);
                p2_req = 1'b1; p2_row = ROW_W'(20 + i); p2_col = COL_W'(2 * i);
            end else begin
                idle_inputs();
            end
            #1;
            check($sformatf("t2_excl_c%0d", i), p1_gnt & p2_gnt, 0);
            if (i < 6) begin
                check($sformatf("t2_gnt1_c%0d", i), p1_gnt, (i % 2 == 0));
                check($sformatf("t2_gnt2_c%0d", i), p2_gnt, (i % 2 == 1));
            end
            if (i >= 3 && i < 9) begin
                check($sformatf("t2_v1_c%0d", i), p1_valid, ((i - 3) % 2 == 0));
                check($sformatf("t2_v2_c%0d", i), p2_valid, ((i - 3) % 2 == 1));
                if ((i - 3) % 2 == 0)
                    check($sformatf("t2_d1_c%0d", i), p1_data, rom_f(10 + i - 3, i - 3));
                else
                    check($sformatf("t2_d2_c%0d", i), p2_data, rom_f(20 + i - 3, 2 * (i - 3)));
            end else begin
                check($sformatf("t2_vnone_c%0d", i), p1_valid | p2_valid, 0);
            end
            tick();
        end

        // P1 locked burst, P2 waiting from cycle 2: hand-off after MAX_BURST grants.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            p1_req = 1'b1; p1_lock = 1'b1; p1_row = 1; p1_col = COL_W'(c);
            p2_req = (c >= 2); p2_row = 2; p2_col = COL_W'(c);
            #1;
            check($sformatf("t3_gnt1_c%0d", c), p1_gnt, (c <= 15 || c == 17));
            check($sformatf("t3_gnt2_c%0d", c), p2_gnt, (c == 16));
            tick();
        end

        // Long burst with P2 idle: counter saturates, P2 wins as soon as it asks.
        do_reset();
        for (int c = 0; c < 40; c++) begin
            p1_req = 1'b1; p1_lock = 1'b1; p1_row = 9; p1_col = COL_W'(c);
            #1;
            check($sformatf("t4_gnt1_c%0d", c), p1_gnt, 1);
            tick();
        end
        p2_req = 1'b1; p2_row = 11; p2_col = 12;
        #1;
        check("t4_gnt2_c40", p2_gnt, 1);
        check("t4_gnt1_c40", p1_gnt, 0);
        tick();

        // Reset in the middle of back-to-back P1 reads.
        do_reset();
        p1_req = 1'b1; p1_row = 4; p1_col = 1;
        #1;
        check("t5_gnt1_c0", p1_gnt, 1);
        tick();
        p1_row = 5; p1_col = 2;
        #1;
        check("t5_gnt1_c1", p1_gnt, 1);
        tick();
        reset = 1'b1;
        #1;
        check("t5_gnt1_rst", p1_gnt, 0);
        check("t5_valid_rst", p1_valid, 0);
        check("t5_data_rst", p1_data, 0);
        check("t5_row_rst", rom_row, 0);
        check("t5_col_rst", rom_col, 0);
        tick();
        reset = 1'b0; p1_row = 7; p1_col = 9;
        #1;
        check("t5_gnt1_c3", p1_gnt, 1);
        check("t5_valid_c3", p1_valid, 0);
        tick();
        p1_req = 1'b0;
        #1;
        check("t5_valid_c4", p1_valid, 0);
        check("t5_row_c4", rom_row, 7);
        check("t5_col_c4", rom_col, 9);
        tick();
        check("t5_valid_c5", p1_valid, 0);
        tick();
        check("t5_valid_c6", p1_valid, 1);
        check("t5_data_c6", p1_data, rom_f(7, 9));
        tick();
        check("t5_valid_c7", p1_valid, 0);

        // P2 pulses its request during a P1 burst and withdraws before any grant.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            p1_req = (c < 8); p1_lock = 1'b1; p1_row = 30; p1_col = COL_W'(c);
            p2_req = (c == 2); p2_row = 6; p2_col = 6;
            #1;
            if (c < 8) check($sformatf("t6_gnt1_c%0d", c), p1_gnt, 1);
            check($sformatf("t6_gnt2_c%0d", c), p2_gnt, 0);
            check($sformatf("t6_v2_c%0d", c), p2_valid, 0);
            if (c >= 3 && c < 11) begin
                check($sformatf("t6_v1_c%0d", c), p1_valid, 1);
                check($sformatf("t6_d1_c%0d", c), p1_data, rom_f(30, c - 3));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares the single registered-address player sprite ROM between two sprite renderers (P1 and P2 fighters) in the VGA pixel pipeline.
- Arbitration is round-robin, with an optional locked burst so a renderer can stream a scanline segment.
- Read data is routed back to the requester that issued the access, tagged with a valid pulse.
- The block sits between the per-player draw logic and the ROM instance, and drives the ROM's row/col inputs.

Parameters:
ROW_W, 10, ROM row address width
COL_W, 10, ROM column address width
COLOR_W, 12, ROM colour word width (4:4:4 RGB)
MAX_BURST, 16, max consecutive locked grants before forced hand-off (>=1)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
p1_req  in  1  P1 read request; P1 holds it with address stable until granted
p1_lock  in  1  P1 requests burst ownership (sampled with req)
p1_row  in  ROW_W  P1 sprite row
p1_col  in  COL_W  P1 sprite col
p1_gnt  out  1  combinational grant; accept = p1_req & p1_gnt at rising edge
p1_valid  out  1  one-cycle pulse: p1_data holds a returned pixel
p1_data  out  COLOR_W  returned colour word
p2_req, p2_lock, p2_row, p2_col, p2_gnt, p2_valid, p2_data  (same as P1, for P2)
rom_row  out  ROW_W  registered row address to ROM
rom_col  out  COL_W  registered col address to ROM
rom_data  in  COLOR_W  ROM colour output (valid one cycle after rom_row/rom_col change)

Behaviour:
- Reset (async, active-high): state=IDLE, rr pointer favours P1, burst_cnt=0, tag pipeline cleared, p*_valid=0, p*_data=0, rom_row=rom_col=0. p*_gnt forced 0 while reset is high.
- At most one grant per cycle; p1_gnt & p2_gnt never both high. A grant is never raised for a requester whose req is low.
- IDLE arbitration:
  - only one req high -> grant it;
  - both high -> grant the requester favoured by rr.
  - On every accept, rr is set to favour the other requester.
- OWN1 / OWN2 (burst owner X, other Y):
  - gnt X if X_req and (burst_cnt<MAX_BURST or !Y_req);
  - otherwise arbitrate as IDLE with Y favoured.
- Next state, evaluated at the edge:
  - accept by X with X_lock=1 -> OWNX. burst_cnt = (state was OWNX) ? sat_inc(burst_cnt) : 1, saturating at MAX_BURST.
  - accept with lock=0 -> IDLE.
  - no accept -> IDLE, burst_cnt=0.
- Accept edge E0 (cycle T):
  - rom_row/rom_col <= winner address;
  - tag stage0 <= {valid=1, id=winner}.
- Edge E1: tag stage1 <= stage0; the ROM registers the address internally.
- Edge E2: if stage1.valid, then <id>_data <= rom_data and <id>_valid <= 1; the other requester's valid = 0.
- Latency: valid/data appear in cycle T+3. Throughput is one access per cycle with back-to-back accepts fully pipelined.
- Data routing:
  - p*_data holds its last value when valid is low;
  - valid is high exactly one cycle per accepted request;
  - return order equals accept order.
- No accept in a cycle: rom_row/rom_col hold, stage0.valid=0.
- A request withdrawn before a grant is legal and produces no response. Address changes while req is high and ungranted are legal; the address sampled is the one present at the accept edge.
- Reset mid-operation: all in-flight tags are dropped; no valid pulses after reset deasserts for accesses accepted before reset.
- MAX_BURST=1: lock still allowed; owner is preempted every cycle the other requester is requesting.

Test Plan:
- Reset, then single P1 read: p1_req=1, row=3, col=5 in cycle 0 -> p1_gnt=1 in cycle 0; rom_row=3, rom_col=5 in cycle 1; p1_valid=1 with p1_data=ROM[3,5] in cycle 3 only; p2_valid stays 0.
- Both request continuously, lock=0 -> grants alternate P1,P2,P1,P2; each valid arrives 3 cycles after its grant with correct data and id; never both gnt.
- P1 req+lock held, P2 requests from cycle 2, MAX_BURST=16 -> P1 granted cycles 0..15; P2 granted cycle 16; P1 next granted cycle 17.
- P1 locked burst, P2 idle, 40 cycles -> P1 granted all 40 cycles (burst_cnt saturates); P2 raises req -> granted on the next cycle.
- Back-to-back P1 accepts on cycles 0..3, reset asserted in cycle 2 for one cycle -> no p1_valid after reset release; all outputs at reset values; next request after release returns correctly with 3-cycle latency.
- P2 raises then drops req before grant while P1 holds the lock -> no p2_valid ever; P1 burst uninterrupted.
